// File: rtl/mod_n_updown_counter.sv
// Modulo-N up/down counter with enable, clear, clamped parallel load, terminal-count pulse
// and optional rising-edge tick qualifier. Define UPDN_CNT_SATURATE_EN to saturate instead of wrap.
module mod_n_updown_counter #(
    parameter int WIDTH    = 8,
    parameter int MOD_N    = 60,
    parameter int EDGE_SEL = 0
) (
    input  logic             clk,
    input  logic             reset_p,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up_dn,
    input  logic             tick,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             zero
);

    localparam longint unsigned MAX_N = 64'd1 << WIDTH;
    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MOD_N - 1);

    generate
        if (MOD_N < 2 || longint'(MOD_N) > MAX_N) begin : gen_bad_mod
            $error("mod_n_updown_counter: MOD_N must satisfy 2 <= MOD_N <= 2**WIDTH");
        end
    endgenerate

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             cnt_event;
    logic             at_max, at_min;

    // Edge register only exists when the rising-edge qualifier is selected.
    generate
        if (EDGE_SEL != 0) begin : gen_edge
            logic tick_prev_q;
            logic tick_prev_d;

            assign tick_prev_d = tick;

            always_ff @(posedge clk) begin
                if (reset_p) begin
                    tick_prev_q <= 1'b0;
                end else begin
                    tick_prev_q <= tick_prev_d;
                end
            end

            assign cnt_event = tick & ~tick_prev_q;
        end else begin : gen_level
            assign cnt_event = tick;
        end
    endgenerate

    assign at_max = (count_q == MAX_CNT);
    assign at_min = (count_q == '0);

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (en && load) begin
            count_d = (load_val > MAX_CNT) ? MAX_CNT : load_val;
        end else if (en && cnt_event) begin
            if (up_dn) begin
                if (at_max) begin
                    tc_d = 1'b1;
`ifdef UPDN_CNT_SATURATE_EN
                    count_d = MAX_CNT;
`else
                    count_d = '0;
`endif
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (at_min) begin
                    tc_d = 1'b1;
`ifdef UPDN_CNT_SATURATE_EN
                    count_d = '0;
`else
                    count_d = MAX_CNT;
`endif
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign zero  = at_min;

endmodule
